regfile_dump_reader: RTL and testbench

//  Sequential reader that walks the 32x32 register file through one read-select port and streams

---
 rtl/regdump_pkg.sv | 17 +
 rtl/regfile_dump_reader.sv | 125 ++++++++++++
 tb/tb_regfile_dump_reader.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regdump_pkg.sv
// Shared types and default sizes for the register-file dump reader.
// Sizes match the 32x32 integer register file.
package regdump_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_WORDS       = 32;
  localparam int DEF_SELECT_SIZE = 5;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
    CSUM,
    DONE
  } regdump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks the register file and streams each word out over valid/ready.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum beat.
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int WORDS       = DEF_WORDS,
  parameter int SELECT_SIZE = DEF_SELECT_SIZE
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [SELECT_SIZE-1:0] reg_sel_o,
  input  logic [DATA_WIDTH-1:0]  reg_data_i,
  output logic [DATA_WIDTH-1:0]  m_data_o,
  output logic [SELECT_SIZE-1:0] m_index_o,
  output logic                   m_last_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i
);

  localparam logic [SELECT_SIZE-1:0] LAST =
    SELECT_SIZE'(WORDS - 1);

`ifdef REGDUMP_CHECKSUM_EN
  localparam logic HAS_CSUM = 1'b1;
  logic [DATA_WIDTH-1:0] checksum;
`else
  localparam logic HAS_CSUM = 1'b0;
`endif

  regdump_state_t state;
  logic [SELECT_SIZE-1:0] idx;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= IDLE;
      idx       <= '0;
      reg_sel_o <= '0;
      m_data_o  <= '0;
      m_index_o <= '0;
      m_last_o  <= 1'b0;
      m_valid_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else if (abort_i && state != IDLE) begin
      // Abort may drop a pending beat; nothing further is sent.
      state     <= IDLE;
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state     <= READ;
            idx       <= '0;
            reg_sel_o <= '0;
            busy_o    <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
            checksum  <= '0;
`endif
          end
        end
        READ: begin
          m_data_o  <= reg_data_i;
          m_index_o <= idx;
          m_valid_o <= 1'b1;
          m_last_o  <= (idx == LAST) && !HAS_CSUM;
          state     <= SEND;
        end
        SEND: begin
          if (m_ready_i) begin
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            checksum  <= checksum ^ m_data_o;
`endif
            if (idx != LAST) begin
              idx       <= idx + 1'b1;
              reg_sel_o <= idx + 1'b1;
              state     <= READ;
            end else begin
`ifdef REGDUMP_CHECKSUM_EN
              // Checksum beat follows with no bubble.
              m_data_o  <= checksum ^ m_data_o;
              m_index_o <= '0;
              m_last_o  <= 1'b1;
              m_valid_o <= 1'b1;
              state     <= CSUM;
`else
              done_o    <= 1'b1;
              state     <= DONE;
`endif
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        CSUM: begin
          if (m_ready_i) begin
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
            done_o    <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed + randomized bench for regfile_dump_reader.
// Reference stream is rebuilt from the register array for each dump.
module tb_regfile_dump_reader;
  import regdump_pkg::*;

  localparam int NW = 32;
`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic [31:0] m_data;
  logic [4:0]  m_index;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;

  logic [31:0] regs [NW];

  typedef struct {
    logic [31:0] d;
    logic [4:0]  i;
    logic        l;
    int          c;
  } beat_t;

  beat_t got[$];
  beat_t exp_q[$];
  int cyc = 0;
  int done_cnt = 0;
  int checks = 0;
  int errors = 0;
  int t0, d0, n;

  regfile_dump_reader dut (
    .clk_i(clk), .reset_ni(reset_n),
    .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done),
    .reg_sel_o(reg_sel), .reg_data_i(reg_data),
    .m_data_o(m_data), .m_index_o(m_index),
    .m_last_o(m_last), .m_valid_o(m_valid),
    .m_ready_i(m_ready)
  );

  always #5 clk = ~clk;

  assign reg_data = regs[reg_sel];

  always @(posedge clk) begin
    if (m_valid && m_ready)
      got.push_back('{m_data, m_index, m_last, cyc});
    if (done) done_cnt++;
    cyc++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NW; i++) regs[i] = $urandom;
    regs[0]  = 32'h0;
    regs[4]  = 32'h0000_0028;
    regs[10] = 32'h0000_0012;
    regs[14] = 32'hBEEF_DEAD;
  endtask

  task automatic build_expected();
    logic [31:0] x;
    x = '0;
    exp_q.delete();
    for (int i = 0; i < NW; i++) begin
      exp_q.push_back('{regs[i], 5'(i),
                        (i == NW - 1) && !CS, 0});
      x = x ^ regs[i];
    end
    if (CS) exp_q.push_back('{x, 5'd0, 1'b1, 0});
  endtask

  task automatic compare_stream(input string tag);
    int m;
    chk({tag, "_count"}, got.size(), exp_q.size());
    m = got.size() < exp_q.size() ? got.size() : exp_q.size();
    for (int k = 0; k < m; k++) begin
      chk($sformatf("%s_data%0d", tag, k), got[k].d, exp_q[k].d);
      chk($sformatf("%s_idx%0d", tag, k), got[k].i, exp_q[k].i);
      chk($sformatf("%s_last%0d", tag, k), got[k].l, exp_q[k].l);
    end
  endtask

  task automatic start_dump();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w;
    w = 0;
    while (done_cnt == d0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_done_seen"}, done_cnt != d0, 1);
  endtask

  task automatic wait_read(input logic [4:0] s,
                           input string tag);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(!m_valid && busy && reg_sel == s) && w < 200);
    chk({tag, "_reached"}, w < 200, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    m_ready = 1'b1;
    fill_random();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_sel", reg_sel, 0);
    chk("rst_data", m_data, 0);
    chk("rst_index", m_index, 0);
    reset_n = 1'b1;

    // 1: full dump, sink always ready
    got.delete();
    build_expected();
    d0 = done_cnt;
    start_dump();
    chk("t1_busy", busy, 1);
    wait_done("t1");
    repeat (2) @(negedge clk);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_busy_end", busy, 0);
    compare_stream("t1");
    if (got.size() > 0) chk("t1_latency", got[0].c, t0 + 2);
    n = 0;
    for (int k = 1; k < got.size() && k < NW; k++)
      if (got[k].c - got[k-1].c != 2) n++;
    chk("t1_gaps", n, 0);

    // 2: backpressure on beat 10
    got.delete();
    build_expected();
    d0 = done_cnt;
    start_dump();
    wait_read(5'd10, "t2");
    m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t2_hold_valid", m_valid, 1);
      chk("t2_hold_data", m_data, 32'h12);
      chk("t2_hold_idx", m_index, 10);
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("t2_bubble", m_valid, 0);
    @(negedge clk);
    chk("t2_next_valid", m_valid, 1);
    chk("t2_next_idx", m_index, 11);
    wait_done("t2");
    repeat (2) @(negedge clk);
    compare_stream("t2");

    // 3: abort while beat 7 is pending
    got.delete();
    start_dump();
    wait_read(5'd7, "t3");
    m_ready = 1'b0;
    @(negedge clk);
    chk("t3_pend_idx", m_index, 7);
    d0 = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_valid", m_valid, 0);
    chk("t3_busy", busy, 0);
    m_ready = 1'b1;
    repeat (80) @(negedge clk);
    chk("t3_no_done", done_cnt, d0);
    chk("t3_beats", got.size(), 7);
    got.delete();
    build_expected();
    start_dump();
    wait_done("t3r");
    repeat (2) @(negedge clk);
    compare_stream("t3r");

    // 4: async reset mid-dump, then random ready + stray starts
    got.delete();
    start_dump();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_valid && m_index == 5'd20) && n < 200);
    chk("t4_reached", n < 200, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_valid", m_valid, 0);
    chk("t4_last", m_last, 0);
    chk("t4_done", done, 0);
    chk("t4_sel", reg_sel, 0);
    chk("t4_data", m_data, 0);
    chk("t4_index", m_index, 0);
    @(negedge clk);
    reset_n = 1'b1;
    fill_random();
    got.delete();
    build_expected();
    d0 = done_cnt;
    start_dump();
    n = 0;
    while (done_cnt == d0 && n < 1000) begin
      @(negedge clk);
      n++;
      if (done_cnt != d0) break;
      m_ready = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    m_ready = 1'b1;
    chk("t4_done_seen", done_cnt != d0, 1);
    repeat (3) @(negedge clk);
    chk("t4_done_pulses", done_cnt - d0, 1);
    compare_stream("t4");

`ifdef REGDUMP_CHECKSUM_EN
    // 5: checksum beat over 0..31
    for (int i = 0; i < NW; i++) regs[i] = 32'(i);
    got.delete();
    build_expected();
    d0 = done_cnt;
    start_dump();
    wait_done("t5");
    repeat (2) @(negedge clk);
    compare_stream("t5");
    if (got.size() == NW + 1) begin
      chk("t5_csum", got[NW].d, 32'h0);
      chk("t5_csum_idx", got[NW].i, 0);
      chk("t5_csum_last", got[NW].l, 1);
      chk("t5_r31_last", got[NW-1].l, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
